task_13: RTL and testbench

Sequence checker for the free-running WIDTH-bit counter stream produced by task_12. Samples the counter value each valid cycle, acquires lock after a run of consecutive increments, then flags every sample that breaks the modulo-2^WIDTH increment sequence. Sits on the receive side of the counter link and feeds a saturating error count to status logic.

---
 rtl/task_pkg.sv | 16 +
 rtl/task_13_sat_counter.sv | 26 ++
 rtl/task_13.sv | 124 ++++++++++++
 tb/tb_task_13.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/task_pkg.sv
// Shared definitions for the counter link: checker state encoding and default word width.
package task_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/task_13_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a coincident increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/task_13.sv
// Sequence checker for a free-running modulo-2^WIDTH counter stream: hunts, locks after
// LOCK_N good increments, flags mismatches while locked and drops lock after LOSE_N in a row.
module task_13
  import task_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int LOCK_N = 3,
  parameter int LOSE_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_vld,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output state_t           dbg_state
);

  localparam int MC_W = $clog2(max_int(LOCK_N, LOSE_N) + 1);
  localparam logic [MC_W-1:0] LOCK_C = MC_W'(LOCK_N);
  localparam logic [MC_W-1:0] LOSE_C = MC_W'(LOSE_N);

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_exp, w_exp_nxt;
  logic [MC_W-1:0]   r_match_cnt, w_match_nxt;
  logic [MC_W-1:0]   r_miss_cnt, w_miss_nxt;
  logic              r_err, w_err_nxt;

  logic              w_hit;
  logic [WIDTH-1:0]  w_exp_inc;
  logic [WIDTH-1:0]  w_in_inc;
  logic [MC_W-1:0]   w_match_inc;
  logic [MC_W-1:0]   w_miss_inc;

  assign w_hit       = (in == r_exp);
  assign w_exp_inc   = r_exp + WIDTH'(1);
  assign w_in_inc    = in + WIDTH'(1);
  assign w_match_inc = r_match_cnt + MC_W'(1);
  assign w_miss_inc  = r_miss_cnt + MC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_exp       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_exp       <= w_exp_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // While locked, a mismatch still advances exp (flywheel) so one glitch does not resync.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_err_nxt   = 1'b0;
    if (in_vld) begin
      unique case (r_state)
        HUNT: begin
          w_exp_nxt   = w_in_inc;
          w_match_nxt = '0;
          w_state_nxt = SYNC;
        end
        SYNC: begin
          if (w_hit) begin
            w_exp_nxt   = w_exp_inc;
            w_match_nxt = w_match_inc;
            if (w_match_inc == LOCK_C) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_exp_nxt   = w_in_inc;
            w_match_nxt = '0;
          end
        end
        LOCKED: begin
          w_exp_nxt = w_exp_inc;
          if (w_hit) begin
            w_miss_nxt = '0;
          end else begin
            w_err_nxt  = 1'b1;
            w_miss_nxt = w_miss_inc;
            if (w_miss_inc == LOSE_C) begin
              w_state_nxt = HUNT;
            end
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (r_err_inc_w()),
    .i_clr (err_clr),
    .o_cnt (err_cnt)
  );

  function automatic logic r_err_inc_w();
    return w_err_nxt;
  endfunction

  assign locked    = (r_state == LOCKED);
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_task_13.sv
// Self-checking bench for task_13: scenario tasks compare DUT outputs against fixed
// expectations and a behavioural model of the sequence checker.
module tb_task_13;
  import task_pkg::*;

  localparam int WIDTH  = 4;
  localparam int LOCK_N = 3;
  localparam int LOSE_N = 2;
  localparam int CNT_W  = 8;
  localparam int MODW   = 1 << WIDTH;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in;
  logic             in_vld;
  logic             err_clr;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  state_t           dbg_state;

  int errors;
  int checks;

  // Behavioural model: phase 0 = hunting, 1 = counting good increments, 2 = locked.
  int m_phase;
  int m_exp;
  int m_run;
  int m_miss;
  bit m_locked;
  bit m_err;
  int m_cnt;

  task_13 #(
    .WIDTH (WIDTH),
    .LOCK_N(LOCK_N),
    .LOSE_N(LOSE_N),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_vld   (in_vld),
    .err_clr  (err_clr),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit r, input int v, input bit vld, input bit clr);
    if (r) begin
      m_phase = 0; m_exp = 0; m_run = 0; m_miss = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_err = 0;
      if (vld) begin
        if (m_phase == 0) begin
          m_exp = (v + 1) % MODW; m_run = 0; m_phase = 1;
        end else if (m_phase == 1) begin
          if (v == m_exp) begin
            m_exp = (m_exp + 1) % MODW;
            m_run++;
            if (m_run >= LOCK_N) begin m_phase = 2; m_miss = 0; end
          end else begin
            m_exp = (v + 1) % MODW; m_run = 0;
          end
        end else begin
          m_exp = (m_exp + 1) % MODW;
          if (v == m_exp - 1 || (m_exp == 0 && v == MODW - 1)) begin
            m_miss = 0;
          end else begin
            m_err = 1;
            m_miss++;
            if (m_miss >= LOSE_N) m_phase = 0;
          end
        end
      end
      if (clr) m_cnt = 0;
      else if (m_err && m_cnt < CMAX) m_cnt++;
    end
    m_locked = (m_phase == 2);
  endtask

  // Apply one cycle of inputs, advance the model, then settle past the edge for sampling.
  task automatic drive(input bit r, input int v, input bit vld, input bit clr);
    rst = r; in = WIDTH'(v); in_vld = vld; err_clr = clr;
    @(posedge clk);
    model_step(r, v, vld, clr);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", err_cnt); end
    for (int i = 0; i < 3; i++) drive(0, $urandom_range(0, 15), 0, 0);
    checks++; if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_idle: got locked=%0b err=%0b cnt=%0d want 0/0/0", locked, err, err_cnt);
    end
  endtask

  task automatic test_acquire();
    int seq[4] = '{5, 6, 7, 8};
    for (int i = 0; i < 4; i++) begin
      drive(0, seq[i], 1, 0);
      checks++; if (locked !== (i == 3)) begin errors++; $display("FAIL acquire_locked[%0d]: got %0b want %0b", i, locked, (i == 3)); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL acquire_err[%0d]: got %0b want 0", i, err); end
    end
  endtask

  task automatic test_wrap();
    int v;
    v = m_exp;
    for (int i = 0; i < 27; i++) begin
      drive(0, v, 1, 0);
      v = (v + 1) % MODW;
      checks++; if (locked !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL wrap[%0d]: got locked=%0b err=%0b want 1/0", i, locked, err);
      end
    end
  endtask

  task automatic align_to(input int target);
    drive(0, m_exp, 1, 1);
    for (int i = 0; i < MODW && m_exp != target; i++) drive(0, m_exp, 1, 0);
    checks++; if (err_cnt !== 8'd0 || locked !== 1'b1) begin
      errors++; $display("FAIL align: got cnt=%0d locked=%0b want 0/1", err_cnt, locked);
    end
  endtask

  task automatic test_glitch();
    int seq[3] = '{9, 4, 5};
    align_to(3);
    for (int i = 0; i < 3; i++) begin
      drive(0, seq[i], 1, 0);
      checks++; if (err !== (i == 0)) begin errors++; $display("FAIL glitch_err[%0d]: got %0b want %0b", i, err, (i == 0)); end
      checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL glitch_cnt[%0d]: got %0d want 1", i, err_cnt); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL glitch_locked[%0d]: got %0b want 1", i, locked); end
    end
  endtask

  task automatic test_loss();
    int seq[4] = '{2, 3, 4, 5};
    align_to(3);
    drive(0, 9, 1, 0);
    checks++; if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b1) begin
      errors++; $display("FAIL loss_first: got err=%0b cnt=%0d locked=%0b want 1/1/1", err, err_cnt, locked);
    end
    drive(0, 9, 1, 0);
    checks++; if (err !== 1'b1 || err_cnt !== 8'd2 || locked !== 1'b0) begin
      errors++; $display("FAIL loss_second: got err=%0b cnt=%0d locked=%0b want 1/2/0", err, err_cnt, locked);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, seq[i], 1, 0);
      checks++; if (locked !== (i == 3) || err !== 1'b0) begin
        errors++; $display("FAIL relock[%0d]: got locked=%0b err=%0b want %0b/0", i, locked, err, (i == 3));
      end
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) drive(0, $urandom_range(0, 15), 0, 0);
      else drive(0, m_exp, 1, 0);
      checks++; if (locked !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL gaps[%0d]: got locked=%0b err=%0b want 1/0", i, locked, err);
      end
    end
  endtask

  task automatic test_clr_coincident();
    drive(0, (m_exp + $urandom_range(1, 15)) % MODW, 1, 1);
    checks++; if (err !== 1'b1 || err_cnt !== 8'd0 || locked !== 1'b1) begin
      errors++; $display("FAIL clr_coinc: got err=%0b cnt=%0d locked=%0b want 1/0/1", err, err_cnt, locked);
    end
    drive(0, m_exp, 1, 0);
    checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL clr_after: got err=%0b cnt=%0d want 0/0", err, err_cnt);
    end
  endtask

  task automatic test_saturate();
    int injected;
    injected = 0;
    drive(0, m_exp, 1, 1);
    for (int i = 0; i < 3000 && injected < 300; i++) begin
      if (m_phase == 2) drive(0, (m_exp + $urandom_range(1, 15)) % MODW, 1, 0);
      else drive(0, m_exp, 1, 0);
      if (m_err) injected++;
      checks++; if (err_cnt !== CNT_W'(m_cnt) || err !== m_err || locked !== m_locked) begin
        errors++; $display("FAIL sat[%0d]: got cnt=%0d err=%0b locked=%0b want %0d/%0b/%0b", i, err_cnt, err, locked, m_cnt, m_err, m_locked);
      end
    end
    checks++; if (injected < 300) begin errors++; $display("FAIL sat_budget: got %0d errors want 300", injected); end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d want 255", err_cnt); end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : m_exp;
      drive(($urandom_range(0, 199) == 0), v, ($urandom_range(0, 4) != 0), ($urandom_range(0, 29) == 0));
      checks++; if (locked !== m_locked || err !== m_err || err_cnt !== CNT_W'(m_cnt)) begin
        errors++; $display("FAIL random[%0d]: got locked=%0b err=%0b cnt=%0d want %0b/%0b/%0d", i, locked, err, err_cnt, m_locked, m_err, m_cnt);
      end
    end
  endtask

  task automatic ensure_locked();
    for (int i = 0; i < 40 && m_phase != 2; i++) drive(0, m_exp, 1, 0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ensure_locked: got %0b want 1", locked); end
  endtask

  task automatic test_reset_locked();
    ensure_locked();
    drive(0, (m_exp + 5) % MODW, 1, 0);
    drive(1, m_exp, 1, 0);
    checks++; if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_locked: got locked=%0b err=%0b cnt=%0d want 0/0/0", locked, err, err_cnt);
    end
    drive(0, 0, 0, 0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_after: got %0b want 0", locked); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; in = '0; in_vld = 1'b0; err_clr = 1'b0;
    model_step(1, 0, 0, 0);
    test_reset();
    test_acquire();
    test_wrap();
    test_glitch();
    test_loss();
    test_gaps();
    test_clr_coincident();
    test_saturate();
    ensure_locked();
    test_clr_coincident();
    test_random();
    test_reset_locked();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
